// File: rtl/ras_predictor.sv
// Return address stack for the fetch unit: predicts return targets and pushes call return addresses.
// Optional saturating performance counters are compiled in when RAS_PERF_COUNTER_EN is defined.
module ras_predictor #(
    parameter int FETCH_WIDTH     = 4,
    parameter int RAS_ENTRY_NUM   = 16,
    parameter int PC_WIDTH        = 32,
    parameter int INSN_BYTE_WIDTH = 4,
    localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int PTR_W  = $clog2(RAS_ENTRY_NUM),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetchValid,
    input  logic                   stall,
    input  logic [PC_WIDTH-1:0]    fetchPC,
    input  logic [FETCH_WIDTH-1:0] btbHit,
    input  logic [FETCH_WIDTH-1:0] isPush,
    input  logic [FETCH_WIDTH-1:0] isPop,
    output logic [PC_WIDTH-1:0]    popTarget,
    output logic                   popValid,
    output logic [LANE_W-1:0]      popLane,
    output logic [PTR_W-1:0]       stackPtr,
    output logic [CNT_W-1:0]       stackCount,
    output logic [PC_WIDTH-1:0]    stackTop,
    input  logic                   recover,
    input  logic [PTR_W-1:0]       recoverPtr,
    input  logic [CNT_W-1:0]       recoverCount,
    input  logic [PC_WIDTH-1:0]    recoverTop
`ifdef RAS_PERF_COUNTER_EN
    ,
    output logic [31:0]            rasPushCount,
    output logic [31:0]            rasOverflowCount,
    output logic [31:0]            rasUnderflowCount
`endif
);

    logic [PC_WIDTH-1:0] entries [RAS_ENTRY_NUM];
    logic [PTR_W-1:0]    ptrQ;
    logic [CNT_W-1:0]    countQ;

    logic                hitFound;
    logic [LANE_W-1:0]   hitLane;
    logic                opPush;
    logic                opPop;
    logic                stackFull;
    logic                stackNonEmpty;
    logic [PTR_W-1:0]    ptrInc;
    logic [PTR_W-1:0]    ptrDec;
    logic [PC_WIDTH-1:0] laneOffset;
    logic [PC_WIDTH-1:0] retAddr;

    // The first BTB hit ends the fetch group, so scanning downward leaves the lowest hit lane.
    always_comb begin
        hitFound = 1'b0;
        hitLane  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (btbHit[i]) begin
                hitFound = 1'b1;
                hitLane  = LANE_W'(i);
            end
        end
    end

    always_comb begin
        opPush        = fetchValid & hitFound & isPush[hitLane];
        opPop         = fetchValid & hitFound & isPop[hitLane];
        stackFull     = (countQ == CNT_W'(RAS_ENTRY_NUM));
        stackNonEmpty = (countQ != '0);
        ptrInc        = ptrQ + PTR_W'(1);
        ptrDec        = ptrQ - PTR_W'(1);
        laneOffset    = PC_WIDTH'((32'(hitLane) + 32'd1) * 32'(INSN_BYTE_WIDTH));
        retAddr       = fetchPC + laneOffset;
    end

    always_comb begin
        popValid   = opPop & stackNonEmpty;
        popTarget  = popValid ? entries[ptrQ] : '0;
        popLane    = popValid ? hitLane : '0;
        stackPtr   = ptrQ;
        stackCount = countQ;
        stackTop   = entries[ptrQ];
    end

    // Recovery outranks stall and fetch; a full stack push silently overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptrQ   <= '0;
            countQ <= '0;
            for (int k = 0; k < RAS_ENTRY_NUM; k++) begin
                entries[k] <= '0;
            end
        end else if (recover) begin
            ptrQ                <= recoverPtr;
            countQ              <= recoverCount;
            entries[recoverPtr] <= recoverTop;
        end else if (!stall) begin
            if (opPush && opPop) begin
                entries[ptrQ] <= retAddr;
                if (!stackNonEmpty) begin
                    countQ <= CNT_W'(1);
                end
            end else if (opPush) begin
                ptrQ            <= ptrInc;
                entries[ptrInc] <= retAddr;
                if (!stackFull) begin
                    countQ <= countQ + CNT_W'(1);
                end
            end else if (opPop && stackNonEmpty) begin
                ptrQ   <= ptrDec;
                countQ <= countQ - CNT_W'(1);
            end
        end
    end

`ifdef RAS_PERF_COUNTER_EN
    // Counters only advance on cycles where the stack itself is allowed to change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rasPushCount      <= '0;
            rasOverflowCount  <= '0;
            rasUnderflowCount <= '0;
        end else if (!stall && !recover) begin
            if (opPush && (rasPushCount != '1)) begin
                rasPushCount <= rasPushCount + 32'd1;
            end
            if (opPush && !opPop && stackFull && (rasOverflowCount != '1)) begin
                rasOverflowCount <= rasOverflowCount + 32'd1;
            end
            if (opPop && !opPush && !stackNonEmpty && (rasUnderflowCount != '1)) begin
                rasUnderflowCount <= rasUnderflowCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ras_predictor.sv
// Self-checking bench for ras_predictor: directed scenarios plus randomized traffic against a stack model.
module tb_ras_predictor;

    localparam int FW = 4;
    localparam int RN = 16;
    localparam int PW = 32;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetchValid;
    logic          stall;
    logic [PW-1:0] fetchPC;
    logic [FW-1:0] btbHit;
    logic [FW-1:0] isPush;
    logic [FW-1:0] isPop;
    logic [PW-1:0] popTarget;
    logic          popValid;
    logic [1:0]    popLane;
    logic [3:0]    stackPtr;
    logic [4:0]    stackCount;
    logic [PW-1:0] stackTop;
    logic          recover;
    logic [3:0]    recoverPtr;
    logic [4:0]    recoverCount;
    logic [PW-1:0] recoverTop;

    int passCount  = 0;
    int checkCount = 0;

    logic [PW-1:0] mEntry [RN];
    int            mPtr;
    int            mCount;
    logic          expValid;
    logic [PW-1:0] expTarget;
    logic [1:0]    expLane;

    always #5 clk = ~clk;

    ras_predictor #(
        .FETCH_WIDTH(FW), .RAS_ENTRY_NUM(RN), .PC_WIDTH(PW), .INSN_BYTE_WIDTH(IB)
    ) dut (
        .clk(clk), .rst(rst), .fetchValid(fetchValid), .stall(stall), .fetchPC(fetchPC),
        .btbHit(btbHit), .isPush(isPush), .isPop(isPop), .popTarget(popTarget),
        .popValid(popValid), .popLane(popLane), .stackPtr(stackPtr), .stackCount(stackCount),
        .stackTop(stackTop), .recover(recover), .recoverPtr(recoverPtr),
        .recoverCount(recoverCount), .recoverTop(recoverTop)
    );

    function automatic int findLane();
        for (int i = 0; i < FW; i++) if (btbHit[i]) return i;
        return -1;
    endfunction

    task automatic modelOutputs();
        int l = findLane();
        expValid  = 1'b0;
        expTarget = '0;
        expLane   = '0;
        if (fetchValid && l >= 0 && isPop[l] && mCount > 0) begin
            expValid  = 1'b1;
            expTarget = mEntry[mPtr];
            expLane   = 2'(l);
        end
    endtask

    task automatic modelCommit();
        int l = findLane();
        logic [PW-1:0] ret;
        if (rst) begin
            mPtr = 0; mCount = 0;
            for (int k = 0; k < RN; k++) mEntry[k] = '0;
        end else if (recover) begin
            mPtr = int'(recoverPtr); mCount = int'(recoverCount);
            mEntry[mPtr] = recoverTop;
        end else if (!stall && fetchValid && l >= 0) begin
            ret = fetchPC + 32'((l + 1) * IB);
            if (isPush[l] && isPop[l]) begin
                mEntry[mPtr] = ret;
                if (mCount < 1) mCount = 1;
            end else if (isPush[l]) begin
                mPtr = (mPtr + 1) % RN;
                mEntry[mPtr] = ret;
                if (mCount < RN) mCount = mCount + 1;
            end else if (isPop[l] && mCount > 0) begin
                mPtr = (mPtr + RN - 1) % RN;
                mCount = mCount - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic idleInputs();
        fetchValid = 1'b0; stall = 1'b0; fetchPC = '0;
        btbHit = '0; isPush = '0; isPop = '0;
        recover = 1'b0; recoverPtr = '0; recoverCount = '0; recoverTop = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clk);
        checkCount++; if (popValid !== 1'b0) $display("[TB] FAIL reset_popValid actual=%0h expected=0", popValid); else passCount++;
        checkCount++; if (popTarget !== '0) $display("[TB] FAIL reset_popTarget actual=%0h expected=0", popTarget); else passCount++;
        checkCount++; if (popLane !== 2'd0) $display("[TB] FAIL reset_popLane actual=%0h expected=0", popLane); else passCount++;
        checkCount++; if (stackPtr !== 4'd0) $display("[TB] FAIL reset_stackPtr actual=%0h expected=0", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd0) $display("[TB] FAIL reset_stackCount actual=%0h expected=0", stackCount); else passCount++;
        checkCount++; if (stackTop !== '0) $display("[TB] FAIL reset_stackTop actual=%0h expected=0", stackTop); else passCount++;
    endtask

    task automatic test_call_return();
        doReset();
        fetchValid = 1'b1; fetchPC = 32'h1000; btbHit = 4'b0100; isPush = 4'b0100; isPop = 4'b0000;
        tick();
        checkCount++; if (stackTop !== 32'h100C) $display("[TB] FAIL call_stackTop actual=%0h expected=100c", stackTop); else passCount++;
        checkCount++; if (stackPtr !== 4'd1) $display("[TB] FAIL call_stackPtr actual=%0d expected=1", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd1) $display("[TB] FAIL call_stackCount actual=%0d expected=1", stackCount); else passCount++;
        btbHit = 4'b0001; isPush = 4'b0000; isPop = 4'b0001;
        #2;
        checkCount++; if (popValid !== 1'b1) $display("[TB] FAIL ret_popValid actual=%0h expected=1", popValid); else passCount++;
        checkCount++; if (popTarget !== 32'h100C) $display("[TB] FAIL ret_popTarget actual=%0h expected=100c", popTarget); else passCount++;
        checkCount++; if (popLane !== 2'd0) $display("[TB] FAIL ret_popLane actual=%0d expected=0", popLane); else passCount++;
        tick();
        idleInputs();
        checkCount++; if (stackCount !== 5'd0) $display("[TB] FAIL ret_stackCount actual=%0d expected=0", stackCount); else passCount++;
        checkCount++; if (stackPtr !== 4'd0) $display("[TB] FAIL ret_stackPtr actual=%0d expected=0", stackPtr); else passCount++;
    endtask

    task automatic test_lane_masking();
        fetchValid = 1'b1; fetchPC = 32'h4000; btbHit = 4'b0001; isPush = 4'b0001; isPop = 4'b0000;
        tick();
        btbHit = 4'b0011; isPush = 4'b0010; isPop = 4'b0010;
        #2;
        checkCount++; if (popValid !== 1'b0) $display("[TB] FAIL mask_popValid actual=%0h expected=0", popValid); else passCount++;
        tick();
        idleInputs();
        checkCount++; if (stackPtr !== 4'd1) $display("[TB] FAIL mask_stackPtr actual=%0d expected=1", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd1) $display("[TB] FAIL mask_stackCount actual=%0d expected=1", stackCount); else passCount++;
        checkCount++; if (stackTop !== 32'h4004) $display("[TB] FAIL mask_stackTop actual=%0h expected=4004", stackTop); else passCount++;
    endtask

    task automatic test_overflow();
        logic [PW-1:0] want;
        doReset();
        for (int k = 0; k < 17; k++) begin
            fetchValid = 1'b1; fetchPC = 32'h2000 + 32'(k * 32'h100);
            btbHit = 4'b0001; isPush = 4'b0001; isPop = 4'b0000;
            tick();
        end
        idleInputs();
        checkCount++; if (stackCount !== 5'd16) $display("[TB] FAIL ovf_stackCount actual=%0d expected=16", stackCount); else passCount++;
        checkCount++; if (stackPtr !== 4'd1) $display("[TB] FAIL ovf_stackPtr actual=%0d expected=1", stackPtr); else passCount++;
        checkCount++; if (stackTop !== 32'h3004) $display("[TB] FAIL ovf_stackTop actual=%0h expected=3004", stackTop); else passCount++;
        for (int j = 0; j < 16; j++) begin
            fetchValid = 1'b1; btbHit = 4'b0001; isPush = 4'b0000; isPop = 4'b0001;
            want = 32'h3004 - 32'(j * 32'h100);
            #2;
            checkCount++; if (popValid !== 1'b1) $display("[TB] FAIL ovf_pop%0d_popValid actual=%0h expected=1", j, popValid); else passCount++;
            checkCount++; if (popTarget !== want) $display("[TB] FAIL ovf_pop%0d_popTarget actual=%0h expected=%0h", j, popTarget, want); else passCount++;
            tick();
        end
        #2;
        checkCount++; if (popValid !== 1'b0) $display("[TB] FAIL ovf_pop16_popValid actual=%0h expected=0", popValid); else passCount++;
        tick();
        idleInputs();
    endtask

    task automatic test_underflow();
        fetchValid = 1'b1; btbHit = 4'b0001; isPush = 4'b0000; isPop = 4'b0001;
        #2;
        checkCount++; if (popValid !== 1'b0) $display("[TB] FAIL unf_popValid actual=%0h expected=0", popValid); else passCount++;
        checkCount++; if (popTarget !== '0) $display("[TB] FAIL unf_popTarget actual=%0h expected=0", popTarget); else passCount++;
        checkCount++; if (popLane !== 2'd0) $display("[TB] FAIL unf_popLane actual=%0d expected=0", popLane); else passCount++;
        tick();
        idleInputs();
        checkCount++; if (stackPtr !== 4'd1) $display("[TB] FAIL unf_stackPtr actual=%0d expected=1", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd0) $display("[TB] FAIL unf_stackCount actual=%0d expected=0", stackCount); else passCount++;
    endtask

    task automatic test_recover();
        fetchValid = 1'b1; fetchPC = 32'h6000; btbHit = 4'b0001; isPush = 4'b0001; isPop = 4'b0000;
        recover = 1'b1; recoverPtr = 4'd5; recoverCount = 5'd3; recoverTop = 32'hABC0;
        tick();
        idleInputs();
        checkCount++; if (stackPtr !== 4'd5) $display("[TB] FAIL rec_stackPtr actual=%0d expected=5", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd3) $display("[TB] FAIL rec_stackCount actual=%0d expected=3", stackCount); else passCount++;
        checkCount++; if (stackTop !== 32'hABC0) $display("[TB] FAIL rec_stackTop actual=%0h expected=abc0", stackTop); else passCount++;
    endtask

    task automatic test_stall();
        stall = 1'b1; fetchValid = 1'b1; fetchPC = 32'h5000; btbHit = 4'b0001; isPush = 4'b0001;
        tick();
        checkCount++; if (stackPtr !== 4'd5) $display("[TB] FAIL stallpush_stackPtr actual=%0d expected=5", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd3) $display("[TB] FAIL stallpush_stackCount actual=%0d expected=3", stackCount); else passCount++;
        checkCount++; if (stackTop !== 32'hABC0) $display("[TB] FAIL stallpush_stackTop actual=%0h expected=abc0", stackTop); else passCount++;
        btbHit = 4'b1000; isPush = 4'b0000; isPop = 4'b1000;
        #2;
        checkCount++; if (popValid !== 1'b1) $display("[TB] FAIL stallpop_popValid actual=%0h expected=1", popValid); else passCount++;
        checkCount++; if (popTarget !== 32'hABC0) $display("[TB] FAIL stallpop_popTarget actual=%0h expected=abc0", popTarget); else passCount++;
        checkCount++; if (popLane !== 2'd3) $display("[TB] FAIL stallpop_popLane actual=%0d expected=3", popLane); else passCount++;
        tick();
        idleInputs();
        checkCount++; if (stackCount !== 5'd3) $display("[TB] FAIL stallpop_stackCount actual=%0d expected=3", stackCount); else passCount++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            fetchValid = 1'b1; fetchPC = 32'h7000 + 32'(k * 16); btbHit = 4'b0010; isPush = 4'b0010; isPop = 4'b0000;
            tick();
        end
        idleInputs();
        checkCount++; if (stackCount !== 5'd7) $display("[TB] FAIL mid_prerst_stackCount actual=%0d expected=7", stackCount); else passCount++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkCount++; if (stackPtr !== 4'd0) $display("[TB] FAIL mid_stackPtr actual=%0d expected=0", stackPtr); else passCount++;
        checkCount++; if (stackCount !== 5'd0) $display("[TB] FAIL mid_stackCount actual=%0d expected=0", stackCount); else passCount++;
        checkCount++; if (stackTop !== '0) $display("[TB] FAIL mid_stackTop actual=%0h expected=0", stackTop); else passCount++;
        checkCount++; if (popValid !== 1'b0 || popTarget !== '0 || popLane !== 2'd0) $display("[TB] FAIL mid_popOutputs actual=%0h/%0h/%0d expected=0/0/0", popValid, popTarget, popLane); else passCount++;
        fetchValid = 1'b1; btbHit = 4'b0001; isPop = 4'b0001;
        #2;
        checkCount++; if (popValid !== 1'b0) $display("[TB] FAIL mid_pop_popValid actual=%0h expected=0", popValid); else passCount++;
        tick();
        idleInputs();
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 99) < 2);
            fetchValid = ($urandom_range(0, 99) < 85);
            stall      = ($urandom_range(0, 99) < 10);
            recover    = ($urandom_range(0, 99) < 5);
            fetchPC    = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            btbHit     = 4'($urandom());
            isPush     = 4'($urandom());
            isPop      = 4'($urandom());
            recoverPtr = 4'($urandom());
            recoverCount = 5'($urandom_range(0, RN));
            recoverTop = $urandom();
            #2;
            modelOutputs();
            checkCount++; if (popValid !== expValid) $display("[TB] FAIL rnd%0d_popValid actual=%0h expected=%0h", c, popValid, expValid); else passCount++;
            checkCount++; if (popTarget !== expTarget) $display("[TB] FAIL rnd%0d_popTarget actual=%0h expected=%0h", c, popTarget, expTarget); else passCount++;
            checkCount++; if (popLane !== expLane) $display("[TB] FAIL rnd%0d_popLane actual=%0d expected=%0d", c, popLane, expLane); else passCount++;
            checkCount++; if (int'(stackPtr) != mPtr) $display("[TB] FAIL rnd%0d_stackPtr actual=%0d expected=%0d", c, stackPtr, mPtr); else passCount++;
            checkCount++; if (int'(stackCount) != mCount) $display("[TB] FAIL rnd%0d_stackCount actual=%0d expected=%0d", c, stackCount, mCount); else passCount++;
            checkCount++; if (stackTop !== mEntry[mPtr]) $display("[TB] FAIL rnd%0d_stackTop actual=%0h expected=%0h", c, stackTop, mEntry[mPtr]); else passCount++;
            tick();
        end
        rst = 1'b0;
        idleInputs();
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        mPtr = 0;
        mCount = 0;
        for (int k = 0; k < RN; k++) mEntry[k] = '0;
        test_reset();
        test_call_return();
        test_lane_masking();
        test_overflow();
        test_underflow();
        test_recover();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
